// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// Measures the high time of an incoming servo/ESC-style PWM pulse train in clk
// cycles. Each legal pulse is converted to an 8-bit speed code
// (high_time - W_MIN). Out-of-range pulses are flagged. Loss of signal is
// reported when no rising edge is seen for TIMEOUT cycles.
//
// Parameters
//   W_MIN    shortest legal high time (clk cycles), maps to code 0
//   W_MAX    longest legal high time (clk cycles), maps to code W_MAX-W_MIN
//            (W_MAX-W_MIN must fit in 8 bits)
//   TIMEOUT  cycles without a rising edge before the signal is declared lost
//   CNT_W    width of the width/period counters, 2^CNT_W-1 >= TIMEOUT
//
// Ports
//   clk          single clock for the whole block
//   rst          asynchronous, active-low reset
//   pwm_in       asynchronous PWM input
//   data_out     last valid speed code (forced to 0 on signal loss)
//   data_valid   one-cycle pulse when data_out takes a new measured code
//   width_err    one-cycle pulse when a measured pulse is out of range
//   signal_lost  level, high while no valid PWM is present
// -----------------------------------------------------------------------------
module pwm_capture #(
    parameter int W_MIN   = 229,
    parameter int W_MAX   = 371,
    parameter int TIMEOUT = 1214,
    parameter int CNT_W   = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       width_err,
    output logic       signal_lost
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] W_MIN_C   = CNT_W'(W_MIN);
    localparam logic [CNT_W-1:0] W_MAX_C   = CNT_W'(W_MAX);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    // Synchronizer (s1, s2) plus edge-detect delay flop (s3)
    logic             s1_reg;
    logic             s2_reg;
    logic             s3_reg;

    // fill_reg marks when s2 holds a real sample of pwm_in rather than its
    // reset value; armed_reg is set once a genuine low has been seen. Together
    // they stop a pulse that is already high at reset release from being
    // taken as a rising edge.
    logic [1:0]       fill_reg;
    logic             armed_reg;

    logic [CNT_W-1:0] wcnt_reg;
    logic [CNT_W-1:0] pcnt_reg;
    state_t           state_reg;

    logic             rise;
    logic             fall;
    logic             timeout;
    logic             in_range;

    assign rise     = s2_reg & ~s3_reg;
    assign fall     = ~s2_reg & s3_reg;
    assign timeout  = (pcnt_reg == TIMEOUT_C);
    assign in_range = (wcnt_reg >= W_MIN_C) && (wcnt_reg <= W_MAX_C);

    // Input synchronizer and arming logic
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            s3_reg    <= 1'b0;
            fill_reg  <= 2'b00;
            armed_reg <= 1'b0;
        end else begin
            s1_reg   <= pwm_in;
            s2_reg   <= s1_reg;
            s3_reg   <= s2_reg;
            fill_reg <= {fill_reg[0], 1'b1};
            if (fill_reg[1] && !s2_reg) begin
                armed_reg <= 1'b1;
            end
        end
    end

    // Width and period counters, both saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_reg <= '0;
            pcnt_reg <= '0;
        end else begin
            if (rise) begin
                wcnt_reg <= CNT_W'(1);
            end else if (state_reg == HIGH && wcnt_reg != CNT_SAT) begin
                wcnt_reg <= wcnt_reg + CNT_W'(1);
            end

            if (rise) begin
                pcnt_reg <= '0;
            end else if (pcnt_reg != CNT_SAT) begin
                pcnt_reg <= pcnt_reg + CNT_W'(1);
            end
        end
    end

    // Measurement FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            data_out    <= 8'd0;
            data_valid  <= 1'b0;
            width_err   <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            data_valid <= 1'b0;
            width_err  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (rise && armed_reg) begin
                        state_reg <= HIGH;
                    end
                end

                HIGH: begin
                    // A timeout coinciding with the fall wins: the input
                    // is treated as stuck high and nothing is reported.
                    if (timeout) begin
                        state_reg   <= IDLE;
                        signal_lost <= 1'b1;
                        data_out    <= 8'd0;
                    end else if (fall) begin
                        state_reg <= LOW;
                        if (in_range) begin
                            data_out    <= 8'(wcnt_reg - W_MIN_C);
                            data_valid  <= 1'b1;
                            signal_lost <= 1'b0;
                        end else begin
                            width_err <= 1'b1;
                        end
                    end
                end

                LOW: begin
                    // TIMEOUT cycles have elapsed since the last rise when
                    // the timeout fires, so it takes precedence.
                    if (timeout) begin
                        state_reg   <= IDLE;
                        signal_lost <= 1'b1;
                        data_out    <= 8'd0;
                    end else if (rise) begin
                        state_reg <= HIGH;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart to the speed PWM generator. The block measures the high time of an incoming servo/ESC-style PWM pulse train in `clk` cycles and converts it to an 8-bit speed code. It flags out-of-range pulses and loss of signal. It sits between an external PWM input pin (for example, an RC receiver or a loopback of the generator output) and the control logic that consumes the 8-bit code.

## Interface
- `W_MIN`, default 229: shortest legal high time, in clk cycles; maps to code 0.
- `W_MAX`, default 371: longest legal high time, in clk cycles; maps to code `W_MAX-W_MIN` (142). `W_MAX-W_MIN` must be ≤ 255.
- `TIMEOUT`, default 1214: clk cycles without a rising edge before the signal is declared lost.
- `CNT_W`, default 11: width of the width and period counters; must satisfy 2^CNT_W-1 ≥ `TIMEOUT`.

- `clk` (input, 1): single clock for the whole block.
- `rst` (input, 1): asynchronous, active-low reset. All state clears while low.
- `pwm_in` (input, 1): asynchronous PWM input.
- `data_out` (output, 8): last valid speed code.
- `data_valid` (output, 1): one-cycle pulse when `data_out` updates.
- `width_err` (output, 1): one-cycle pulse when a measured pulse is outside [`W_MIN`, `W_MAX`].
- `signal_lost` (output, 1): level; high while no valid PWM is present.

## Operation
- `pwm_in` passes through a 2-flop synchronizer (`s1`, `s2`) and then a delay flop `s3`.
  - `rise = s2 & ~s3`
  - `fall = ~s2 & s3`
- Width counter `wcnt` (CNT_W bits):
  - loads 1 on `rise`;
  - increments each cycle while in HIGH;
  - saturates at all-ones.
- Period counter `pcnt` (CNT_W bits):
  - clears on `rise`;
  - otherwise increments each cycle, saturating at all-ones.
- States:
  - **IDLE**: entered at reset or on timeout. `rise` → HIGH. A pulse already high when leaving reset is ignored until a full low→high transition is seen.
  - **HIGH**: counting the high time.
    - `fall` → LOW and evaluate `wcnt`.
    - `pcnt == TIMEOUT` → IDLE (input stuck high).
  - **LOW**:
    - `rise` → HIGH.
    - `pcnt == TIMEOUT` → IDLE.
- Evaluation on `fall`:
  - **`W_MIN ≤ wcnt ≤ W_MAX`**:
    - `data_out <= wcnt - W_MIN`, truncated to 8 bits;
    - pulse `data_valid`;
    - clear `signal_lost`.
  - **Otherwise**:
    - pulse `width_err`;
    - `data_out` and `signal_lost` are unchanged.
- Timeout, on the transition to IDLE caused by `pcnt == TIMEOUT`:
  - `signal_lost <= 1`;
  - `data_out <= 0`, so a consumer sees stop, not a stale speed;
  - no `data_valid` pulse.
- `data_valid` and `width_err` are never high in the same cycle.

## Timing
- Reset values:
  - `data_out` = 0
  - `data_valid` = 0
  - `width_err` = 0
  - `signal_lost` = 1
  - state IDLE; all synchronizer flops and counters 0.
- The reset takes effect immediately on `rst` falling. Reset mid-pulse discards the partial measurement, and the next full pulse after reset release is measured.
- Latency: if `pwm_in` is first sampled low at clk edge k, `data_valid`/`width_err` is high during the cycle after edge k+2. This is 3 cycles, fixed.
- Accuracy: for a `pwm_in` high time of exactly N cycles (synchronous stimulus), measured `wcnt` = N. Both edges see identical synchronizer delay.
- Saturation: a pulse longer than 2^CNT_W-1 cycles reports `wcnt` = all-ones and gives `width_err`, unless the timeout fires first.
- Timeout: `signal_lost` rises on the cycle after `pcnt` reaches `TIMEOUT`, i.e. `TIMEOUT`+3 cycles after the last `pwm_in` rise is sampled.
- Simultaneous `fall` and `pcnt == TIMEOUT` in HIGH: the timeout wins. Go to IDLE, with no evaluation pulse.
- Back-to-back pulses with a low time of 1 cycle are measured correctly: `fall` and the next `rise` are 1 cycle apart, and LOW handles `rise` immediately.

## Test plan
1. **Reset:** hold `rst` low, toggle `pwm_in`. Required: `data_out` = 0, `data_valid` = 0, `width_err` = 0, `signal_lost` = 1 throughout.
2. **Valid pulses:** period 607 cycles, high times 300, 229 and 371 cycles. Required: `data_valid` pulses 3 cycles after each fall, with `data_out` = 71, 0 and 142 respectively. `signal_lost` drops on the first pulse.
3. **Out-of-range:** after a valid 300-cycle pulse, send a 200-cycle pulse, then a 400-cycle pulse. Required: two single-cycle `width_err` pulses, no `data_valid`, and `data_out` stays 71.
4. **Signal loss:** after a valid pulse, hold `pwm_in` low for 1300 cycles. Required: `signal_lost` = 1 and `data_out` = 0 at `TIMEOUT`+3 cycles after the last rise. The next valid 250-cycle pulse gives `data_out` = 21 and `signal_lost` = 0.
5. **Stuck high:** raise `pwm_in` and hold it high for 2000 cycles. Required: IDLE with `signal_lost` = 1 at `TIMEOUT`+3 cycles after the rise, and no `width_err` when the input finally falls.
6. **Reset mid-pulse:** assert `rst` 100 cycles into a 300-cycle pulse and release it while `pwm_in` is still high. Required: no evaluation pulse for that partial pulse; the next full 300-cycle pulse gives `data_out` = 71.
